// File: rtl/seg7_pkg.sv
// Shared constants and types for the 4-digit common-anode 7-segment scan controller.
// Segment patterns are active low, ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

   localparam logic [6:0] SEG_OFF = 7'h7F;
   localparam logic [3:0] AN_OFF  = 4'hF;

   typedef logic [1:0] digit_idx_t;

   localparam logic [6:0] HEX_SEG [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble to active-low 7-segment pattern.
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for a 4-digit common-anode 7-segment display.
// Optional anti-ghost anode blanking at the start of each slot: define SEG7_BLANK_EN.
//
// digit_idx | meaning
// ----------+------------------------------------------
//   0       | rightmost digit (data nibble [3:0]) driven
//   1       | digit 1 (nibble [7:4]) driven
//   2       | digit 2 (nibble [11:8]) driven
//   3       | leftmost digit (nibble [15:12]); slot end is the frame boundary
module seg7_scan_ctrl
   import seg7_pkg::*;
#(
   parameter int TICK_DIV  = 100000,
   parameter int BLANK_CYC = 1000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] data_in,
   input  logic        data_valid,
   output logic        data_ready,
   input  logic [3:0]  digit_en,
   output logic [6:0]  SEG,
   output logic [3:0]  AN,
   output logic        frame_tick
);

   localparam int PW = $clog2(TICK_DIV);

`ifdef SEG7_BLANK_EN
   localparam bit BLANK_EN = 1'b1;
`else
   localparam bit BLANK_EN = 1'b0;
`endif

   logic [PW-1:0] presc;
   digit_idx_t    digit_idx;
   logic [15:0]   active;
   logic [15:0]   pending;
   logic          pending_full;
   logic          slot_tick;
   logic          frame_end;
   logic [3:0]    nibble;
   logic [6:0]    seg_dec;
   logic          digit_on;
   logic          blank;
   logic [6:0]    seg_d;
   logic [3:0]    an_d;

   assign slot_tick  = (presc == PW'(TICK_DIV - 1));
   assign frame_end  = slot_tick && (digit_idx == 2'd3);
   assign data_ready = ~pending_full;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc      <= '0;
         digit_idx  <= '0;
         frame_tick <= 1'b0;
      end else begin
         presc      <= slot_tick ? '0 : presc + 1'b1;
         frame_tick <= frame_end;
         if (slot_tick) begin
            digit_idx <= digit_idx + 2'd1;
         end
      end
   end

   // New data only reaches the display at a frame boundary so a frame never mixes two values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active       <= '0;
         pending      <= '0;
         pending_full <= 1'b0;
      end else begin
         if (frame_end && pending_full) begin
            active       <= pending;
            pending_full <= 1'b0;
         end
         if (data_valid && data_ready) begin
            pending      <= data_in;
            pending_full <= 1'b1;
         end
      end
   end

   assign nibble = active[{digit_idx, 2'b00} +: 4];

   seg7_decode u_decode (
      .nibble (nibble),
      .seg    (seg_dec)
   );

   assign digit_on = digit_en[digit_idx];
   assign blank    = BLANK_EN && (presc < PW'(BLANK_CYC));
   assign seg_d    = digit_on ? seg_dec : SEG_OFF;
   assign an_d     = (digit_on && !blank) ? ~(4'b0001 << digit_idx) : AN_OFF;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         SEG <= SEG_OFF;
         AN  <= AN_OFF;
      end else begin
         SEG <= seg_d;
         AN  <= an_d;
      end
   end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl with a cycle-level behavioural model of the display.
// Honours SEG7_BLANK_EN when the build defines it.
module tb_seg7_scan_ctrl;

   localparam int TD = 4;
   localparam int BC = 1;
`ifdef SEG7_BLANK_EN
   localparam bit BLANK = 1'b1;
`else
   localparam bit BLANK = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] data_in = '0;
   logic        data_valid = 1'b0;
   logic        data_ready;
   logic [3:0]  digit_en = 4'hF;
   logic [6:0]  SEG;
   logic [3:0]  AN;
   logic        frame_tick;

   int n_cmp = 0;
   int n_bad = 0;

   seg7_scan_ctrl #(.TICK_DIV(TD), .BLANK_CYC(BC)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .data_in    (data_in),
      .data_valid (data_valid),
      .data_ready (data_ready),
      .digit_en   (digit_en),
      .SEG        (SEG),
      .AN         (AN),
      .frame_tick (frame_tick)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] hex7(input logic [3:0] v);
      case (v)
         4'h0: hex7 = 7'b1000000; 4'h1: hex7 = 7'b1111001;
         4'h2: hex7 = 7'b0100100; 4'h3: hex7 = 7'b0110000;
         4'h4: hex7 = 7'b0011001; 4'h5: hex7 = 7'b0010010;
         4'h6: hex7 = 7'b0000010; 4'h7: hex7 = 7'b1111000;
         4'h8: hex7 = 7'b0000000; 4'h9: hex7 = 7'b0010000;
         4'hA: hex7 = 7'b0001000; 4'hB: hex7 = 7'b0000011;
         4'hC: hex7 = 7'b1000110; 4'hD: hex7 = 7'b0100001;
         4'hE: hex7 = 7'b0000110; default: hex7 = 7'b0001110;
      endcase
   endfunction

   task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: n counts clock edges since reset release; slot and phase follow by division.
   int          n = 0;
   logic [15:0] m_active = '0;
   logic [15:0] m_pend = '0;
   bit          m_full = 1'b0;
   logic [6:0]  e_seg = 7'h7F;
   logic [3:0]  e_an = 4'hF;
   logic        e_ft = 1'b0;
   logic        e_rdy = 1'b1;

   always @(posedge clk) begin
      int  idx, ph;
      bit  boundary, acc;
      if (!rst_n) begin
         n = 0; m_active = '0; m_pend = '0; m_full = 1'b0;
         e_seg = 7'h7F; e_an = 4'hF; e_ft = 1'b0; e_rdy = 1'b1;
      end else begin
         n++;
         idx = ((n - 1) / TD) % 4;
         ph  = (n - 1) % TD;
         e_seg = digit_en[idx] ? hex7(m_active[idx*4 +: 4]) : 7'h7F;
         e_an  = digit_en[idx] ? ~(4'b0001 << idx) : 4'hF;
         if (BLANK && ph < BC) e_an = 4'hF;
         boundary = (ph == TD - 1) && (idx == 3);
         e_ft = boundary;
         acc = data_valid && !m_full;
         if (boundary && m_full) begin
            m_active = m_pend;
            m_full = 1'b0;
         end
         if (acc) begin
            m_pend = data_in;
            m_full = 1'b1;
         end
         e_rdy = !m_full;
      end
   end

   always @(posedge clk) begin
      #1;
      check("cyc_seg", {9'd0, SEG}, {9'd0, e_seg});
      check("cyc_an", {12'd0, AN}, {12'd0, e_an});
      check("cyc_frame_tick", {15'd0, frame_tick}, {15'd0, e_ft});
      check("cyc_data_ready", {15'd0, data_ready}, {15'd0, e_rdy});
   end

   task automatic wait_ft();
      bit seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (frame_tick) begin
            seen = 1'b1;
            break;
         end
      end
      check("wait_frame_tick", {15'd0, seen}, 16'd1);
   endtask

   initial begin
      bit got;
      int hits;
      repeat (3) @(negedge clk);
      check("rst_seg", {9'd0, SEG}, 16'h007F);
      check("rst_an", {12'd0, AN}, 16'h000F);
      check("rst_ready", {15'd0, data_ready}, 16'd1);
      check("rst_ft", {15'd0, frame_tick}, 16'd0);
      rst_n = 1'b1;

      @(posedge clk); #1;
      check("first_an", {12'd0, AN}, BLANK ? 16'h000F : 16'h000E);
      check("first_seg", {9'd0, SEG}, 16'h0040);
      repeat (15) @(posedge clk);
      #1;
      check("edge16_ft", {15'd0, frame_tick}, 16'd1);
      check("edge16_an", {12'd0, AN}, 16'h0007);
      @(posedge clk); #1;
      check("edge17_ft", {15'd0, frame_tick}, 16'd0);

      @(negedge clk);
      data_in = 16'h1A3F; data_valid = 1'b1;
      @(posedge clk); #1;
      check("ready_drop", {15'd0, data_ready}, 16'd0);
      @(negedge clk);
      data_valid = 1'b0;
      wait_ft();
      @(posedge clk); #1;
      check("d0_F", {9'd0, SEG}, 16'h000E);
      repeat (4) @(posedge clk);
      #1;
      check("d1_3", {9'd0, SEG}, 16'h0030);
      repeat (4) @(posedge clk);
      #1;
      check("d2_A", {9'd0, SEG}, 16'h0008);
      repeat (4) @(posedge clk);
      #1;
      check("d3_1", {9'd0, SEG}, 16'h0079);

      @(negedge clk);
      data_in = 16'hB0B0; data_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      data_in = 16'hC0DE;
      got = 1'b0;
      for (int i = 0; i < 64; i++) begin
         if (data_ready) begin
            got = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("second_accept", {15'd0, got}, 16'd1);
      @(posedge clk);
      @(negedge clk);
      data_valid = 1'b0;
      wait_ft();
      @(posedge clk); #1;
      check("second_d0_E", {9'd0, SEG}, 16'h0006);

      @(negedge clk);
      digit_en = 4'b0101;
      hits = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (AN == 4'hD || AN == 4'h7) hits++;
      end
      check("en_mask_hits", 16'(hits), 16'd0);
      @(negedge clk);
      digit_en = 4'hF;

      @(negedge clk);
      data_in = 16'h5555; data_valid = 1'b1;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_seg", {9'd0, SEG}, 16'h007F);
      check("async_an", {12'd0, AN}, 16'h000F);
      check("async_ready", {15'd0, data_ready}, 16'd1);
      data_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      repeat (16) @(posedge clk);
      #1;
      check("post_rst_d0", {9'd0, SEG}, 16'h0040);

      repeat (4) @(posedge clk);
      #2;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
